// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbCmd   = 2'd1,
    ArbRdata = 2'd2
  } arb_state_e;

  localparam logic ArbOwnInst = 1'b0;
  localparam logic ArbOwnData = 1'b1;

  // Grant vector bit 1 selects the data master, bit 0 the inst master.
  function automatic logic owner_of(input logic [1:0] grant);
    return grant[1] ? ArbOwnData : ArbOwnInst;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-request combinational arbiter producing a one-hot grant.
// ARB_DPRIO_EN selects fixed data-master priority instead of round-robin.
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       req_inst,
  input  logic       req_data,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_inst && req_data) begin
`ifdef ARB_DPRIO_EN
      grant[1] = 1'b1;
`else
      // Favour whichever master did not complete the previous transaction.
      if (last == ArbOwnInst) grant[1] = 1'b1;
      else                    grant[0] = 1'b1;
`endif
    end else if (req_data) begin
      grant[1] = 1'b1;
    end else if (req_inst) begin
      grant[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between inst and data refill masters, one whole
// transaction at a time. Build with ARB_DPRIO_EN for fixed data priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [BE_W-1:0]   inst_byte_en_i,
  input  logic [DATA_W-1:0] inst_writedata_i,
  input  logic              inst_read_i,
  input  logic              inst_write_i,
  output logic [DATA_W-1:0] inst_readdata_o,
  output logic              inst_readdata_valid_o,
  output logic              inst_waitrequest_o,

  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [BE_W-1:0]   data_byte_en_i,
  input  logic [DATA_W-1:0] data_writedata_i,
  input  logic              data_read_i,
  input  logic              data_write_i,
  output logic [DATA_W-1:0] data_readdata_o,
  output logic              data_readdata_valid_o,
  output logic              data_waitrequest_o,

  output logic [ADDR_W-1:0] o_m_addr,
  output logic [BE_W-1:0]   o_m_byte_en,
  output logic [DATA_W-1:0] o_m_writedata,
  output logic              o_m_read,
  output logic              o_m_write,
  input  logic [DATA_W-1:0] i_m_readdata,
  input  logic              i_m_readdata_valid,
  input  logic              i_m_waitrequest
);

  arb_state_e state;
  logic       owner;
  logic       last;
  logic [1:0] grant;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_byte_en;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;

  rr_arb2 u_rr_arb2 (
    .req_inst (inst_read_i | inst_write_i),
    .req_data (data_read_i | data_write_i),
    .last     (last),
    .grant    (grant)
  );

  always_comb begin
    if (grant[1]) begin
      sel_addr      = data_addr_i;
      sel_byte_en   = data_byte_en_i;
      sel_writedata = data_writedata_i;
      sel_read      = data_read_i;
      sel_write     = data_write_i;
    end else begin
      sel_addr      = inst_addr_i;
      sel_byte_en   = inst_byte_en_i;
      sel_writedata = inst_writedata_i;
      sel_read      = inst_read_i;
      sel_write     = inst_write_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ArbIdle;
      owner         <= ArbOwnInst;
      last          <= ArbOwnData;
      o_m_addr      <= '0;
      o_m_byte_en   <= '0;
      o_m_writedata <= '0;
      o_m_read      <= 1'b0;
      o_m_write     <= 1'b0;
    end else begin
      case (state)
        ArbIdle: begin
          if (|grant) begin
            owner         <= owner_of(grant);
            o_m_addr      <= sel_addr;
            o_m_byte_en   <= sel_byte_en;
            o_m_writedata <= sel_writedata;
            // Read wins when a master raises both strobes.
            o_m_read      <= sel_read;
            o_m_write     <= sel_write & ~sel_read;
            state         <= ArbCmd;
          end
        end
        ArbCmd: begin
          if (!i_m_waitrequest) begin
            if (o_m_write) begin
              o_m_write <= 1'b0;
              last      <= owner;
              state     <= ArbIdle;
            end else begin
              o_m_read <= 1'b0;
              if (i_m_readdata_valid) begin
                last  <= owner;
                state <= ArbIdle;
              end else begin
                state <= ArbRdata;
              end
            end
          end
        end
        ArbRdata: begin
          if (i_m_readdata_valid) begin
            last  <= owner;
            state <= ArbIdle;
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

  logic in_cmd;
  logic in_xfer;

  always_comb begin
    in_cmd  = (state == ArbCmd);
    in_xfer = (state == ArbCmd) || (state == ArbRdata);

    inst_readdata_o = i_m_readdata;
    data_readdata_o = i_m_readdata;

    inst_waitrequest_o = (in_cmd && owner == ArbOwnInst) ? i_m_waitrequest : 1'b1;
    data_waitrequest_o = (in_cmd && owner == ArbOwnData) ? i_m_waitrequest : 1'b1;

    inst_readdata_valid_o = i_m_readdata_valid && in_xfer && (owner == ArbOwnInst);
    data_readdata_valid_o = i_m_readdata_valid && in_xfer && (owner == ArbOwnData);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: arbitration vector table plus
// hand-written multi-cycle sequences, read data checked through a scoreboard.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int BE_W   = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;

  logic [ADDR_W-1:0] inst_addr_i, data_addr_i;
  logic [BE_W-1:0]   inst_byte_en_i, data_byte_en_i;
  logic [DATA_W-1:0] inst_writedata_i, data_writedata_i;
  logic              inst_read_i, inst_write_i, data_read_i, data_write_i;
  logic [DATA_W-1:0] inst_readdata_o, data_readdata_o;
  logic              inst_readdata_valid_o, data_readdata_valid_o;
  logic              inst_waitrequest_o, data_waitrequest_o;
  logic [ADDR_W-1:0] o_m_addr;
  logic [BE_W-1:0]   o_m_byte_en;
  logic [DATA_W-1:0] o_m_writedata;
  logic              o_m_read, o_m_write;
  logic [DATA_W-1:0] i_m_readdata;
  logic              i_m_readdata_valid, i_m_waitrequest;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .inst_addr_i           (inst_addr_i),
    .inst_byte_en_i        (inst_byte_en_i),
    .inst_writedata_i      (inst_writedata_i),
    .inst_read_i           (inst_read_i),
    .inst_write_i          (inst_write_i),
    .inst_readdata_o       (inst_readdata_o),
    .inst_readdata_valid_o (inst_readdata_valid_o),
    .inst_waitrequest_o    (inst_waitrequest_o),
    .data_addr_i           (data_addr_i),
    .data_byte_en_i        (data_byte_en_i),
    .data_writedata_i      (data_writedata_i),
    .data_read_i           (data_read_i),
    .data_write_i          (data_write_i),
    .data_readdata_o       (data_readdata_o),
    .data_readdata_valid_o (data_readdata_valid_o),
    .data_waitrequest_o    (data_waitrequest_o),
    .o_m_addr              (o_m_addr),
    .o_m_byte_en           (o_m_byte_en),
    .o_m_writedata         (o_m_writedata),
    .o_m_read              (o_m_read),
    .o_m_write             (o_m_write),
    .i_m_readdata          (i_m_readdata),
    .i_m_readdata_valid    (i_m_readdata_valid),
    .i_m_waitrequest       (i_m_waitrequest)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int inst_valid_cnt = 0;
  int data_valid_cnt = 0;
  logic [DATA_W-1:0] inst_q[$];
  logic [DATA_W-1:0] data_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every forwarded valid must match a queued expectation.
  always @(negedge clk) begin
    if (inst_readdata_valid_o) begin
      inst_valid_cnt++;
      if (inst_q.size() == 0) check("inst_unexpected_valid", 128'd1, 128'd0);
      else check("inst_readdata", inst_readdata_o, inst_q.pop_front());
    end
    if (data_readdata_valid_o) begin
      data_valid_cnt++;
      if (data_q.size() == 0) check("data_unexpected_valid", 128'd1, 128'd0);
      else check("data_readdata", data_readdata_o, data_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_reqs();
    inst_read_i  = 1'b0;
    inst_write_i = 1'b0;
    data_read_i  = 1'b0;
    data_write_i = 1'b0;
  endtask

  typedef struct {
    logic ir, iw, dr, dw;
    logic win_rr;   // 1 = data master expected to win, round-robin build
    logic win_dp;   // same, fixed data-priority build
    logic exp_rd, exp_wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [ADDR_W-1:0] ia, da;
    logic [BE_W-1:0]   ibe, dbe;
    logic [DATA_W-1:0] iwd, dwd, rdat;
    logic              win;
    int                cnt0;

    rst = 1'b1;
    clear_reqs();
    inst_addr_i = '0; data_addr_i = '0;
    inst_byte_en_i = '0; data_byte_en_i = '0;
    inst_writedata_i = '0; data_writedata_i = '0;
    i_m_readdata = '0; i_m_readdata_valid = 1'b0; i_m_waitrequest = 1'b1;

    #1 rst = 1'b0;
    #3;
    check("rst_o_m_read", o_m_read, 0);
    check("rst_o_m_write", o_m_write, 0);
    check("rst_o_m_addr", o_m_addr, 0);
    check("rst_o_m_byte_en", o_m_byte_en, 0);
    check("rst_o_m_writedata", o_m_writedata, 0);
    check("rst_inst_wait", inst_waitrequest_o, 1);
    check("rst_data_wait", data_waitrequest_o, 1);
    check("rst_inst_valid", inst_readdata_valid_o, 0);
    check("rst_data_valid", data_readdata_valid_o, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    //            ir  iw  dr  dw  rr  dp  rd  wr
    vecs[0] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[3] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0};
    vecs[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};
    vecs[6] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};

    for (int i = 0; i < 8; i++) begin
      ia  = 32'h1000_0000 + 32'(i * 16);
      da  = 32'h2000_0000 + 32'(i * 16);
      ibe = 16'hFFF0 | 16'(i);
      dbe = 16'h0F00 | 16'(i);
      iwd = {4{32'hAAAA_0000 + 32'(i)}};
      dwd = {4{32'hDDDD_0000 + 32'(i)}};
`ifdef ARB_DPRIO_EN
      win = vecs[i].win_dp;
`else
      win = vecs[i].win_rr;
`endif
      inst_addr_i = ia; inst_byte_en_i = ibe; inst_writedata_i = iwd;
      data_addr_i = da; data_byte_en_i = dbe; data_writedata_i = dwd;
      inst_read_i = vecs[i].ir; inst_write_i = vecs[i].iw;
      data_read_i = vecs[i].dr; data_write_i = vecs[i].dw;
      tick();
      check($sformatf("v%0d_addr", i), o_m_addr, win ? da : ia);
      check($sformatf("v%0d_byte_en", i), o_m_byte_en, win ? dbe : ibe);
      check($sformatf("v%0d_writedata", i), o_m_writedata, win ? dwd : iwd);
      check($sformatf("v%0d_read", i), o_m_read, vecs[i].exp_rd);
      check($sformatf("v%0d_write", i), o_m_write, vecs[i].exp_wr);
      i_m_waitrequest = 1'b0;
      if (vecs[i].exp_rd) begin
        rdat = {4{32'hC0DE_0000 + 32'(i)}};
        i_m_readdata = rdat;
        i_m_readdata_valid = 1'b1;
        if (win) data_q.push_back(rdat);
        else     inst_q.push_back(rdat);
      end
      #1;
      check($sformatf("v%0d_inst_wait", i), inst_waitrequest_o, win ? 1 : 0);
      check($sformatf("v%0d_data_wait", i), data_waitrequest_o, win ? 0 : 1);
      tick();
      clear_reqs();
      i_m_waitrequest = 1'b1;
      i_m_readdata_valid = 1'b0;
      #1;
      check($sformatf("v%0d_idle_read", i), o_m_read, 0);
      check($sformatf("v%0d_idle_write", i), o_m_write, 0);
    end

    // Inst read, slave accepts at once, data three cycles later.
    cnt0 = inst_valid_cnt;
    inst_addr_i = 32'h3000_0040;
    inst_read_i = 1'b1;
    tick();
    check("a_read_hi", o_m_read, 1);
    check("a_addr", o_m_addr, 32'h3000_0040);
    i_m_waitrequest = 1'b0;
    #1;
    check("a_inst_wait_lo", inst_waitrequest_o, 0);
    check("a_data_wait_hi", data_waitrequest_o, 1);
    tick();
    inst_read_i = 1'b0;
    i_m_waitrequest = 1'b1;
    #1;
    check("a_read_1cycle", o_m_read, 0);
    check("a_inst_wait_rdata", inst_waitrequest_o, 1);
    tick();
    tick();
    rdat = {16{8'hA5}};
    i_m_readdata = rdat;
    i_m_readdata_valid = 1'b1;
    inst_q.push_back(rdat);
    #1;
    check("a_data_valid_lo", data_readdata_valid_o, 0);
    tick();
    i_m_readdata_valid = 1'b0;
    #1;
    check("a_inst_pulses", 32'(inst_valid_cnt - cnt0), 1);
    // Stray valid while idle must be dropped.
    i_m_readdata_valid = 1'b1;
    #1;
    check("stray_inst_valid", inst_readdata_valid_o, 0);
    check("stray_data_valid", data_readdata_valid_o, 0);
    tick();
    i_m_readdata_valid = 1'b0;

    // Data write stalled four cycles, then inst read one idle cycle later.
    data_addr_i = 32'h4000_0080;
    data_writedata_i = {4{32'h1234_5678}};
    data_byte_en_i = 16'h00FF;
    data_write_i = 1'b1;
    i_m_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_write_hold%0d", k), o_m_write, 1);
      check($sformatf("b_addr_hold%0d", k), o_m_addr, 32'h4000_0080);
      check($sformatf("b_data_wait%0d", k), data_waitrequest_o, 1);
      tick();
    end
    i_m_waitrequest = 1'b0;
    inst_addr_i = 32'h5000_0000;
    inst_read_i = 1'b1;
    #1;
    check("b_write_accept", o_m_write, 1);
    check("b_addr_accept", o_m_addr, 32'h4000_0080);
    check("b_data_wait_lo", data_waitrequest_o, 0);
    check("b_inst_wait_hi", inst_waitrequest_o, 1);
    tick();
    data_write_i = 1'b0;
    i_m_waitrequest = 1'b1;
    #1;
    check("b_idle_write", o_m_write, 0);
    check("b_idle_read", o_m_read, 0);
    tick();
    check("b_inst_grant", o_m_read, 1);
    check("b_inst_addr", o_m_addr, 32'h5000_0000);
    // Zero-latency completion: accept and data in the same cycle.
    rdat = {4{32'h0BAD_F00D}};
    i_m_readdata = rdat;
    i_m_waitrequest = 1'b0;
    i_m_readdata_valid = 1'b1;
    inst_q.push_back(rdat);
    tick();
    inst_read_i = 1'b0;
    i_m_waitrequest = 1'b1;
    #1;
    // Valid still high: back in IDLE it must not be forwarded (RDATA would).
    check("z_no_rdata_valid", inst_readdata_valid_o, 0);
    check("z_read_lo", o_m_read, 0);
    tick();
    i_m_readdata_valid = 1'b0;

    // Reset asserted while waiting for read data.
    data_addr_i = 32'h6000_0000;
    data_read_i = 1'b1;
    tick();
    i_m_waitrequest = 1'b0;
    tick();
    data_read_i = 1'b0;
    i_m_waitrequest = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("c_rst_read", o_m_read, 0);
    check("c_rst_addr", o_m_addr, 0);
    check("c_rst_data_wait", data_waitrequest_o, 1);
    check("c_rst_inst_wait", inst_waitrequest_o, 1);
    i_m_readdata = {4{32'hDEAD_BEEF}};
    i_m_readdata_valid = 1'b1;
    #1;
    check("c_rst_data_valid", data_readdata_valid_o, 0);
    check("c_rst_inst_valid", inst_readdata_valid_o, 0);
    tick();
    tick();
    rst = 1'b1;
    i_m_readdata_valid = 1'b0;
    #1;

    // First tie after reset.
    inst_addr_i = 32'h7000_0000;
    data_addr_i = 32'h7100_0000;
    inst_read_i = 1'b1;
    data_read_i = 1'b1;
    tick();
`ifdef ARB_DPRIO_EN
    check("c_tie_addr", o_m_addr, 32'h7100_0000);
`else
    check("c_tie_addr", o_m_addr, 32'h7000_0000);
`endif
    rdat = {4{32'h5A5A_0001}};
    i_m_readdata = rdat;
    i_m_waitrequest = 1'b0;
    i_m_readdata_valid = 1'b1;
`ifdef ARB_DPRIO_EN
    data_q.push_back(rdat);
`else
    inst_q.push_back(rdat);
`endif
    tick();
    clear_reqs();
    i_m_waitrequest = 1'b1;
    i_m_readdata_valid = 1'b0;
    tick();

    check("inst_q_drained", 32'(inst_q.size()), 0);
    check("data_q_drained", 32'(data_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the single external memory port between the instruction-cache refill master and the data-cache refill/writeback master of the rv32i core. Sits between the core's `o_inst_*`/`o_data_*` memory ports and the SoC memory. It grants one whole transaction at a time: a write until accepted, a read until its data returns. Arbitration is round-robin by default.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 128, memory data width (one cache line beat)
- `BE_W`, `DATA_W/8`, byte-enable width
- `clk` input 1: single clock
- `rst` input 1: reset, asynchronous, active-low
- `inst_addr_i`, `inst_byte_en_i`, `inst_writedata_i` input `ADDR_W`/`BE_W`/`DATA_W`: inst master command
- `inst_read_i`, `inst_write_i` input 1: inst master request strobes
- `inst_readdata_o` output `DATA_W`; `inst_readdata_valid_o` output 1; `inst_waitrequest_o` output 1
- `data_addr_i`, `data_byte_en_i`, `data_writedata_i`, `data_read_i`, `data_write_i`: data master, same widths as inst
- `data_readdata_o`, `data_readdata_valid_o`, `data_waitrequest_o`: data master responses
- `o_m_addr` output `ADDR_W`; `o_m_byte_en` output `BE_W`; `o_m_writedata` output `DATA_W`; `o_m_read`, `o_m_write` output 1: slave command, registered
- `i_m_readdata` input `DATA_W`; `i_m_readdata_valid` input 1; `i_m_waitrequest` input 1: slave responses

## Operation
- States: `IDLE`, `CMD`, `RDATA`. Register `owner` (0=inst, 1=data) and `last` (last completed owner).
- `IDLE`: request = read|write per master. None -> stay. One -> grant it. Both -> grant master != `last`. On grant: latch addr/byte_en/writedata/read/write into `o_m_*`, set `owner`, go `CMD`.
- `CMD`: hold `o_m_*`. On `!i_m_waitrequest`:
  - write: deassert `o_m_write`, `last<=owner`, go `IDLE`.
  - read, `i_m_readdata_valid` same cycle: deassert `o_m_read`, `last<=owner`, go `IDLE`.
  - read otherwise: deassert `o_m_read`, go `RDATA`.
- `RDATA`: on `i_m_readdata_valid`: `last<=owner`, go `IDLE`.
- A read is never issued with both read and write set. If a master asserts both, read wins and write is ignored for that grant.
- `*_waitrequest_o` = `i_m_waitrequest` for the owner in `CMD`. It is 1 in every other case: `IDLE`, `RDATA`, and the non-owner.
- `*_readdata_o` = `i_m_readdata` to both masters, combinational.
- `*_readdata_valid_o` = `i_m_readdata_valid` gated to the owner, in `CMD` or `RDATA` only. Stray valids in `IDLE` are dropped.
- Masters must hold their request until their waitrequest is low. A request dropped mid-`CMD` does not abort; the latched transaction completes.

## Timing
- Reset values:
  - state `IDLE`, `owner=0`, `last=1` (inst wins the first tie)
  - `o_m_*` all 0
  - both waitrequest outputs 1, both readdata_valid outputs 0
- Grant latency: request sampled in `IDLE` at cycle n; `o_m_read`/`o_m_write` high at n+1.
- Minimum read turnaround: slave waitrequest low and valid in the same cycle at n+1 gives master data at n+1; arbiter is back in `IDLE` at n+2.
- One `IDLE` cycle always separates transactions. Peak throughput is one transaction per 2 cycles.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronous). Any outstanding slave response is discarded.

## Configuration
- `ARB_DPRIO_EN` defined: fixed priority; the data master always wins a simultaneous request in `IDLE`. `last` is not used for the decision.
- Not defined: round-robin as described above.
- Either way, once granted, a transaction is never preempted.

## Structure
- Shared defines header holds:
  - state encodings `ArbIdle`/`ArbCmd`/`ArbRdata` (2 bits)
  - owner constants `ArbOwnInst`/`ArbOwnData`
- One sub-module, `rr_arb2`: two requests plus `last` in, one-hot grant out. It is combinational and contains the `ARB_DPRIO_EN` switch.
- The FSM and command registers live in `mem_bus_arbiter`.

## Test plan
- Inst read only, slave waitrequest low at once, valid 3 cycles later with 0xA5..A5:
  - `o_m_read` is high for exactly 1 cycle
  - `inst_readdata_valid_o` pulses once with that data
  - `data_readdata_valid_o` stays 0
- Both masters request reads every cycle, no macro:
  - grants alternate inst, data, inst, data
  - first grant is inst after reset
  - waitrequest to the loser stays 1
- Same as above with `ARB_DPRIO_EN`: data granted every time while it keeps requesting.
- Data write, slave waitrequest high for 4 cycles:
  - `o_m_write` and addr held stable 5 cycles
  - `data_waitrequest_o` low only in the accept cycle
  - next inst request is granted 1 cycle later
- Zero-latency slave (waitrequest 0 and valid 1 in the same cycle): read completes with no `RDATA` state; state goes `CMD` to `IDLE`.
- `rst` asserted low in `RDATA`, with a valid arriving during reset:
  - outputs return to reset values immediately
  - no readdata_valid is forwarded to either master
